// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory arbiter: access sizes,
// arbitration modes, byte-strobe generation and the alignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Strobe for an access at lane 0; the caller shifts it to the real lane.
  function automatic logic [7:0] size_to_strobe(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_to_strobe = 8'h01;
      SZ_HALF: size_to_strobe = 8'h03;
      SZ_WORD: size_to_strobe = 8'h0F;
      default: size_to_strobe = 8'hFF;
    endcase
  endfunction

  // wide = 1 when the RAM word is 64 bits, the only case where dword is legal.
  function automatic logic is_aligned(input logic [2:0] low, input logic [1:0] sz,
                                      input logic wide);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = (low[0] == 1'b0);
      SZ_WORD: is_aligned = (low[1:0] == 2'b00);
      default: is_aligned = wide && (low == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-writable synchronous RAM, one byte-wide array per lane, with a
// registered read port (one-cycle latency) and a shared enable.
module dmem_ram #(
  parameter int ADDRESS_LENGTH = 13,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                                                 clk,
  input  logic                                                 en,
  input  logic                                                 we,
  input  logic [DATA_LENGTH/8-1:0]                             be,
  input  logic [ADDRESS_LENGTH-$clog2(DATA_LENGTH/8)-1:0]      waddr,
  input  logic [DATA_LENGTH-1:0]                               wdata,
  output logic [DATA_LENGTH-1:0]                               rdata
);
  localparam int NB    = DATA_LENGTH / 8;
  localparam int DEPTH = 2 ** (ADDRESS_LENGTH - $clog2(NB));

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) lane_mem[waddr] <= wdata[gi*8 +: 8];
        end else begin
          lane_rd_reg <= lane_mem[waddr];
        end
      end
    end

    assign rdata[gi*8 +: 8] = lane_rd_reg;
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// N-port arbiter in front of the shared data RAM: grant selection, store lane
// steering, legality check, response register and load alignment/extension.
module data_memory_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 13,
  parameter int N_PORTS        = 2,
  parameter int ARB_MODE       = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_PORTS-1:0]                  req,
  input  logic [N_PORTS-1:0]                  we,
  input  logic [N_PORTS*ADDRESS_LENGTH-1:0]   addr,
  input  logic [N_PORTS*DATA_LENGTH-1:0]      wdata,
  input  logic [2*N_PORTS-1:0]                size,
  input  logic [N_PORTS-1:0]                  uns,
  output logic [N_PORTS-1:0]                  gnt,
  output logic [N_PORTS-1:0]                  rvalid,
  output logic                                err,
  output logic [DATA_LENGTH-1:0]              rdata
);
  localparam int NB   = DATA_LENGTH / 8;
  localparam int OFFS = $clog2(NB);
  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [ADDRESS_LENGTH-1:0] addr_a  [N_PORTS];
  logic [DATA_LENGTH-1:0]    wdata_a [N_PORTS];
  logic [1:0]                size_a  [N_PORTS];

  logic [PW-1:0] rr_ptr_reg;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign addr_a[gi]  = addr[gi*ADDRESS_LENGTH +: ADDRESS_LENGTH];
    assign wdata_a[gi] = wdata[gi*DATA_LENGTH +: DATA_LENGTH];
    assign size_a[gi]  = size[gi*2 +: 2];
    assign gnt[gi]     = gnt_any && (gnt_idx == PW'(gi));
  end

  // First active request scanning upward from the start point (0 or rr_ptr).
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!rst) begin
      for (int off = 0; off < N_PORTS; off++) begin
        cand = (ARB_MODE == ARB_RR) ? (int'(rr_ptr_reg) + off) % N_PORTS : off;
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(cand);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (gnt_any) begin
      rr_ptr_reg <= (gnt_idx == PW'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  logic [ADDRESS_LENGTH-1:0] sel_addr;
  logic [DATA_LENGTH-1:0]    sel_wdata;
  logic [1:0]                sel_size;
  logic                      sel_we;
  logic                      sel_uns;
  logic [OFFS-1:0]           lane;
  logic                      legal;
  logic [NB-1:0]             strobe;
  logic [DATA_LENGTH-1:0]    wrep;

  always_comb begin
    sel_addr  = addr_a[gnt_idx];
    sel_wdata = wdata_a[gnt_idx];
    sel_size  = size_a[gnt_idx];
    sel_we    = we[gnt_idx];
    sel_uns   = uns[gnt_idx];
    lane      = sel_addr[OFFS-1:0];
    legal     = is_aligned(sel_addr[2:0], sel_size, DATA_LENGTH == 64);
    strobe    = NB'(size_to_strobe(sel_size) << lane);
    case (sel_size)
      SZ_BYTE: wrep = {NB{sel_wdata[7:0]}};
      SZ_HALF: wrep = {(NB/2){sel_wdata[15:0]}};
      SZ_WORD: wrep = {(NB/4){sel_wdata[31:0]}};
      default: wrep = sel_wdata;
    endcase
  end

  logic [DATA_LENGTH-1:0] ram_q;

  dmem_ram #(
    .ADDRESS_LENGTH(ADDRESS_LENGTH),
    .DATA_LENGTH   (DATA_LENGTH)
  ) u_ram (
    .clk  (clk),
    .en   (gnt_any && legal),
    .we   (sel_we),
    .be   (strobe),
    .waddr(sel_addr[ADDRESS_LENGTH-1:OFFS]),
    .wdata(wrep),
    .rdata(ram_q)
  );

  logic            resp_valid_reg;
  logic [PW-1:0]   resp_port_reg;
  logic [OFFS-1:0] resp_lane_reg;
  logic [1:0]      resp_size_reg;
  logic            resp_uns_reg;
  logic            resp_err_reg;
  logic            resp_zero_reg;

  // Access fields only change on a grant, so rdata holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_port_reg  <= '0;
      resp_lane_reg  <= '0;
      resp_size_reg  <= SZ_BYTE;
      resp_uns_reg   <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_zero_reg  <= 1'b1;
    end else begin
      resp_valid_reg <= gnt_any;
      if (gnt_any) begin
        resp_port_reg <= gnt_idx;
        resp_lane_reg <= lane;
        resp_size_reg <= sel_size;
        resp_uns_reg  <= sel_uns;
        resp_err_reg  <= !legal;
        resp_zero_reg <= sel_we || !legal;
      end
    end
  end

  logic [DATA_LENGTH-1:0] shifted;
  logic [DATA_LENGTH-1:0] mask;
  logic                   sign_bit;
  logic [DATA_LENGTH-1:0] ext;

  always_comb begin
    shifted = ram_q >> {resp_lane_reg, 3'b000};
    case (resp_size_reg)
      SZ_BYTE: begin mask = DATA_LENGTH'(64'hFF);        sign_bit = shifted[7];  end
      SZ_HALF: begin mask = DATA_LENGTH'(64'hFFFF);      sign_bit = shifted[15]; end
      SZ_WORD: begin mask = DATA_LENGTH'(64'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin mask = '1;                          sign_bit = 1'b0;        end
    endcase
    ext = shifted & mask;
    if (!resp_uns_reg && sign_bit) ext = ext | ~mask;
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rvalid
    assign rvalid[gi] = resp_valid_reg && !rst && (resp_port_reg == PW'(gi));
  end

  assign err   = resp_valid_reg && resp_err_reg && !rst;
  assign rdata = (rst || resp_zero_reg) ? '0 : ext;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: a byte-array memory model predicts each response at grant
// time; a monitor pops and compares whenever a response is due.
module tb_data_memory_arbiter;
  localparam int DL = 32;
  localparam int AL = 13;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] req, we, uns;
  logic [NP*AL-1:0] addr;
  logic [NP*DL-1:0] wdata;
  logic [2*NP-1:0] size;
  logic [NP-1:0] gnt_rr, rvalid_rr, gnt_fx, rvalid_fx;
  logic err_rr, err_fx;
  logic [DL-1:0] rdata_rr, rdata_fx;

  logic [AL-1:0] p_addr [NP];
  logic [DL-1:0] p_wdata [NP];
  logic [1:0]    p_size [NP];

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      addr[p*AL +: AL]  = p_addr[p];
      wdata[p*DL +: DL] = p_wdata[p];
      size[p*2 +: 2]    = p_size[p];
    end
  end

  data_memory_arbiter #(.DATA_LENGTH(DL), .ADDRESS_LENGTH(AL), .N_PORTS(NP), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size),
    .uns(uns), .gnt(gnt_rr), .rvalid(rvalid_rr), .err(err_rr), .rdata(rdata_rr));

  data_memory_arbiter #(.DATA_LENGTH(DL), .ADDRESS_LENGTH(AL), .N_PORTS(NP), .ARB_MODE(0)) u_fx (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size),
    .uns(uns), .gnt(gnt_fx), .rvalid(rvalid_fx), .err(err_fx), .rdata(rdata_fx));

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  resp_t q[$];
  logic [7:0] mem_m [0:(1<<AL)-1];
  int ptr_m = 0;
  int cyc = 0;
  int checks = 0;
  int passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour for a granted access, from the access rules directly.
  function automatic resp_t predict(input int p);
    resp_t r;
    int nb, a;
    logic [63:0] v;
    nb = 1 << p_size[p];
    a  = int'(p_addr[p]);
    r.port = p;
    r.cyc  = cyc;
    r.err  = 1'b0;
    r.rdata = '0;
    if (p_size[p] == 2'b11 || (a % nb) != 0) begin
      r.err = 1'b1;
    end else if (we[p]) begin
      for (int i = 0; i < nb; i++) mem_m[a + i] = p_wdata[p][8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(mem_m[a + i]) << (8 * i));
      if (!uns[p] && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
      r.rdata = v[31:0];
    end
    return r;
  endfunction

  // Inputs are set just after a falling edge; evaluate this cycle and advance.
  task automatic tick(output int g);
    int gf;
    resp_t r;
    g = -1;
    #1;
    if (rst) begin
      chk("gnt_in_reset", gnt_rr, 0);
      chk("gnt_fx_in_reset", gnt_fx, 0);
      chk("rvalid_in_reset", rvalid_rr | rvalid_fx, 0);
      chk("err_in_reset", err_rr | err_fx, 0);
      chk("rdata_in_reset", rdata_rr | rdata_fx, 0);
      q.delete();
      ptr_m = 0;
    end else begin
      for (int off = 0; off < NP; off++)
        if (g < 0 && req[(ptr_m + off) % NP]) g = (ptr_m + off) % NP;
      gf = -1;
      for (int p = NP - 1; p >= 0; p--) if (req[p]) gf = p;
      chk("gnt_rr", gnt_rr, (g < 0) ? 0 : (1 << g));
      chk("gnt_fixed", gnt_fx, (gf < 0) ? 0 : (1 << gf));
      if (g >= 0) begin
        r = predict(g);
        q.push_back(r);
        ptr_m = (g + 1) % NP;
        $display("txn cyc=%0d port=%0d we=%0b addr=%03h size=%0d uns=%0b wdata=%08h -> err=%0b rdata=%08h",
                 cyc, g, we[g], p_addr[g], p_size[g], uns[g], p_wdata[g], r.err, r.rdata);
      end
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0 && q[0].cyc + 1 == cyc) begin
        e = q.pop_front();
        chk("rvalid", rvalid_rr, 1 << e.port);
        chk("err", err_rr, e.err);
        chk("rdata", rdata_rr, e.rdata);
      end else begin
        chk("rvalid_idle", rvalid_rr, 0);
      end
    end
  end

  task automatic set_port(input int p, input bit w, input int a, input logic [31:0] d,
                          input int sz, input bit u);
    req[p] = 1'b1; we[p] = w; p_addr[p] = AL'(a); p_wdata[p] = d;
    p_size[p] = 2'(sz); uns[p] = u;
  endtask

  task automatic acc(input bit w, input int a, input logic [31:0] d, input int sz, input bit u);
    int g;
    req = '0;
    set_port(0, w, a, d, sz, u);
    tick(g);
    req = '0;
  endtask

  task automatic randomize_port(input int p);
    int sz, a;
    sz = (($urandom % 8) == 0) ? 3 : int'($urandom_range(0, 2));
    a  = int'($urandom_range(0, 63));
    if (($urandom % 4) != 0) a = a & ~((1 << sz) - 1);
    set_port(p, bit'($urandom % 2), a, $urandom, sz, bit'($urandom % 2));
    if (($urandom % 2) == 0) req[p] = 1'b0;
  endtask

  initial begin : stimulus
    int g;
    rst = 1'b1; req = '1; we = '0; uns = '0;
    for (int p = 0; p < NP; p++) begin p_addr[p] = '0; p_wdata[p] = '0; p_size[p] = 2'b10; end
    @(negedge clk);
    repeat (3) tick(g);
    rst = 1'b0; req = '0;
    tick(g);

    for (int a = 0; a < 64; a += 4) acc(1, a, $urandom, 2, 0);

    acc(1, 'h010, 32'hDEADBEEF, 2, 0);
    acc(0, 'h010, 0, 2, 0);
    acc(0, 'h013, 0, 0, 0);
    acc(0, 'h013, 0, 0, 1);
    acc(0, 'h012, 0, 1, 0);
    acc(0, 'h012, 0, 1, 1);
    acc(1, 'h011, 32'h55, 0, 0);
    acc(0, 'h010, 0, 2, 0);
    acc(0, 'h011, 0, 1, 0);
    acc(1, 'h012, 32'h12345678, 2, 0);
    acc(0, 'h010, 0, 3, 0);
    acc(0, 'h010, 0, 2, 1);

    rst = 1'b1; tick(g); rst = 1'b0;
    for (int p = 0; p < NP; p++) set_port(p, 0, 4 * p, 0, 2, 0);
    repeat (6) tick(g);
    req = '0;
    tick(g);

    acc(0, 'h010, 0, 2, 0);
    rst = 1'b1; tick(g); rst = 1'b0;
    tick(g);
    chk("rdata_after_reset", rdata_rr, 0);
    for (int p = 0; p < NP; p++) set_port(p, 0, 4 * p, 0, 2, 0);
    #1;
    chk("post_reset_gnt_port0", gnt_rr, 3'b001);
    tick(g);

    for (int p = 0; p < NP; p++) randomize_port(p);
    for (int n = 0; n < 300; n++) begin
      tick(g);
      for (int p = 0; p < NP; p++) if (!req[p] || p == g) randomize_port(p);
    end

    req = '0;
    tick(g);
    tick(g);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Parametrised N-port front end for the data RAM, replacing the two-way select with a multi-requester arbiter. It sits between the core load/store unit, the interface memory controller and any further bus masters, and a shared byte-writable synchronous RAM. It adds:

- a req/gnt/rvalid handshake;
- fixed or round-robin arbitration;
- byte-lane generation from the byte address and access size;
- read alignment with sign/zero extension;
- registered read data;
- misalignment error reporting.

## Interface
Parameters:
- DATA_LENGTH, 32, word width; 32 or 64 only
- ADDRESS_LENGTH, 13, byte-address width; RAM depth = 2^(ADDRESS_LENGTH-OFFS), OFFS = log2(DATA_LENGTH/8)
- N_PORTS, 2, number of requesters (1..8); port 0 = core
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  in  1  single clock; every register is clocked by clk
- rst  in  1  reset; synchronous, active-high
- req  in  N_PORTS  access request per port, held until granted
- we  in  N_PORTS  1 = store, 0 = load
- addr  in  N_PORTS*ADDRESS_LENGTH  byte address, port i at slice i
- wdata  in  N_PORTS*DATA_LENGTH  store data, right-aligned
- size  in  2*N_PORTS  access size per port: 00 byte, 01 half, 10 word, 11 dword (valid only when DATA_LENGTH=64)
- uns  in  N_PORTS  1 = zero-extend load, 0 = sign-extend
- gnt  out  N_PORTS  one-hot grant; request accepted this cycle
- rvalid  out  N_PORTS  one-cycle completion pulse to the accepted port
- err  out  1  qualifies rvalid; misaligned or illegal size
- rdata  out  DATA_LENGTH  aligned, extended load data; valid with rvalid

## Operation
Grant:
- gnt is combinational from req and the arbitration state, and is at most one-hot.
- gnt is forced to 0 while rst is high.
- Fixed mode: the lowest-index active req wins.
- Round-robin mode: search starts at rr_ptr; on a grant to port k, rr_ptr <= (k+1) mod N_PORTS. rr_ptr is unchanged when there is no grant.

Alignment check (access is legal only if both hold):
- the byte address is a multiple of the access size;
- size 11 is used only with DATA_LENGTH=64.
- Illegal access: no RAM enable, no write. rvalid pulses for that port with err=1 and rdata=0.

Store path:
- Lane index = addr[OFFS-1:0].
- Byte strobe = size mask shifted left by the lane index: byte 1, half 3, word 0xF, dword 0xFF.
- wdata is replicated across lanes so the low bytes land on the strobed lanes.

Load path:
- Full word read from the RAM.
- Registered lane offset, size and uns select and shift the field down, then sign- or zero-extend it to DATA_LENGTH.
- Non-granted ports see rdata but have no rvalid.

## Timing
- Cycle T, grant to port k: RAM enable, address, strobe and data are presented in T.
  - Store: committed at the rising edge ending T.
  - Load: RAM data is available in T+1.
- Cycle T+1: rvalid[k]=1 for exactly one cycle, and for loads rdata is valid.
  - Stores also get rvalid (acknowledge) with rdata=0.
- Throughput: one access per cycle. Back-to-back grants are allowed; in T+1 the rvalid of access n overlaps the gnt of access n+1.
- Read-after-write to the same word in consecutive cycles returns the new data, because the write commits before the read.
- Reset values: rvalid=0, err=0, rdata=0, rr_ptr=0, gnt=0.
- rst asserted in cycle T: the access granted in T-1 gets no rvalid. A store granted in T-1 has already been written.
- Between rvalid pulses rdata holds its last value; no combinational loop.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - ARB_FIXED/ARB_RR;
  - function size_to_strobe;
  - function is_aligned.
- Sub-module dmem_ram:
  - synchronous RAM with per-byte write enable and EN;
  - one-cycle read latency;
  - parameters ADDRESS_LENGTH and DATA_LENGTH.
- The top level contains the arbiter, the lane logic, the response register (port id, lane, size, uns, err, we) and the extension mux.

## Test plan
- Word round-trip: port 0 store 0xDEADBEEF at 0x010, then load word at 0x010 → rvalid[0] at T+1, rdata=0xDEADBEEF, err=0.
- Byte/half extension: after the previous store, load byte 0x013 signed → 0xFFFFFFDE; unsigned → 0x000000DE; load half 0x012 signed → 0xFFFFDEAD.
- Partial store: store byte 0x55 at 0x011 → following word load at 0x010 returns 0xDEAD55EF.
- Round-robin fairness: N_PORTS=3, all req held high for 6 cycles → grants 0,1,2,0,1,2; with ARB_MODE=0 → grants 0 every cycle.
- Misalignment: half load at 0x011 → rvalid with err=1, rdata=0, RAM contents unchanged; size 11 with DATA_LENGTH=32 → err=1.
- Reset mid-operation: assert rst in the cycle after a load grant → rvalid never pulses, rdata=0, and the next grant goes to port 0.
